mem_port_arbiter: RTL and testbench

//  Shares the single byte-wide DRAM port between NUM_REQ loader/store engines (load_v, matrix loader, store path).

---
 rtl/mem_arb_pkg.sv | 21 ++
 rtl/mem_port_arbiter_rr_pick.sv | 38 +++
 rtl/mem_port_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Package: mem_arb_pkg
// Shared types and constants for the DRAM port arbiter.
//   arb_state_t      arbiter FSM state (IDLE, LOCKED)
//   DEFAULT_NUM_REQ  default number of requesting engines
//   DEFAULT_MAX_HOLD default watchdog hold limit in cycles
//   req_idx_w()      width of an engine index for a given engine count
package mem_arb_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    localparam int unsigned DEFAULT_NUM_REQ  = 4;
    localparam int unsigned DEFAULT_MAX_HOLD = 1024;

    function automatic int unsigned req_idx_w(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_pick.sv
// Module: rr_pick
// Combinational round-robin picker: returns the first asserted request at or
// after ptr, wrapping from NUM_REQ-1 back to 0.
// Ports:
//   req   in   NUM_REQ   request vector
//   ptr   in   IDX_W     round-robin start index (must be < NUM_REQ)
//   pick  out  IDX_W     selected index (0 when nothing requests)
//   any   out  1         at least one request asserted
module rr_pick
    import mem_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = DEFAULT_NUM_REQ,
    parameter int unsigned IDX_W   = req_idx_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [IDX_W-1:0]   pick,
    output logic               any
);

    always_comb begin
        int unsigned idx;
        idx  = 0;
        pick = '0;
        any  = 1'b0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = 32'(ptr) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!any && req[IDX_W'(idx)]) begin
                any  = 1'b1;
                pick = IDX_W'(idx);
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Module: mem_port_arbiter
// Shares one byte-wide DRAM port between NUM_REQ engines. Round-robin choice
// with burst lock: the winner keeps the port while its req stays high; one
// dead cycle follows every release. Read responses (1-cycle latency) are
// routed back to the engine that issued the read.
// Optional feature: define MEM_ARB_WATCHDOG_EN to bound a lock to MAX_HOLD
// cycles and raise a sticky err when an owner is forcibly released.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   req_i/we_i            per-engine request / write enable
//   addr_i/wdata_i        per-engine address / write data, engine i at slice i
//   grant_o               one-hot grant (combinational)
//   rdata_o, valid_o      read data broadcast, per-engine read-data valid
//   mem_req/we/addr/wdata to DRAM
//   mem_rdata, mem_valid  from DRAM
//   busy                  port locked to an owner
//   err                   sticky watchdog error
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ    = DEFAULT_NUM_REQ,
    parameter int unsigned ADDR_WIDTH = 24,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned MAX_HOLD   = DEFAULT_MAX_HOLD
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUM_REQ-1:0]               req_i,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]    addr_i,
    input  logic [NUM_REQ-1:0]               we_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    wdata_i,
    output logic [NUM_REQ-1:0]               grant_o,
    output logic [DATA_WIDTH-1:0]            rdata_o,
    output logic [NUM_REQ-1:0]               valid_o,
    output logic                             mem_req,
    output logic                             mem_we,
    output logic [ADDR_WIDTH-1:0]            mem_addr,
    output logic [DATA_WIDTH-1:0]            mem_wdata,
    input  logic [DATA_WIDTH-1:0]            mem_rdata,
    input  logic                             mem_valid,
    output logic                             busy,
    output logic                             err
);

    localparam int unsigned REQ_IDX_W = req_idx_w(NUM_REQ);

    arb_state_t           state, state_nxt;
    logic [REQ_IDX_W-1:0] owner, owner_nxt;
    logic [REQ_IDX_W-1:0] rr_ptr, rr_nxt;
    logic [REQ_IDX_W-1:0] resp_owner;
    logic                 resp_pend;
    logic [REQ_IDX_W-1:0] pick;
    logic                 any_req;
    logic [REQ_IDX_W-1:0] sel_idx;
    logic                 sel_valid;
    logic                 owner_req;
    logic                 wd_trip;

    function automatic logic [REQ_IDX_W-1:0] next_idx(input logic [REQ_IDX_W-1:0] i);
        if (i == REQ_IDX_W'(NUM_REQ - 1)) begin
            return '0;
        end
        return i + 1'b1;
    endfunction

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (REQ_IDX_W)
    ) u_rr_pick (
        .req  (req_i),
        .ptr  (rr_ptr),
        .pick (pick),
        .any  (any_req)
    );

    assign owner_req = req_i[owner];

`ifdef MEM_ARB_WATCHDOG_EN
    localparam int unsigned HOLD_W = $clog2(MAX_HOLD + 1);

    logic [HOLD_W-1:0] hold_cnt;
    logic              err_q;

    assign wd_trip = (state == LOCKED) && owner_req && (hold_cnt == HOLD_W'(MAX_HOLD - 1));

    // Held at zero while IDLE so the first LOCKED cycle always counts from 0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hold_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            if (state == LOCKED) begin
                hold_cnt <= hold_cnt + 1'b1;
            end else begin
                hold_cnt <= '0;
            end
            if (wd_trip) begin
                err_q <= 1'b1;
            end
        end
    end

    assign err = err_q;
`else
    logic unused_max_hold;

    assign wd_trip         = 1'b0;
    assign err             = 1'b0;
    assign unused_max_hold = (MAX_HOLD != 0);
`endif

    // Next-state and selection. While rst_n is low nothing is granted, so a
    // burst in progress loses the port as soon as reset is applied.
    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        rr_nxt    = rr_ptr;
        sel_valid = 1'b0;
        sel_idx   = owner;
        case (state)
            IDLE: begin
                if (any_req) begin
                    sel_valid = 1'b1;
                    sel_idx   = pick;
                    owner_nxt = pick;
                    state_nxt = LOCKED;
                end
            end
            LOCKED: begin
                if (owner_req && !wd_trip) begin
                    sel_valid = 1'b1;
                end else begin
                    state_nxt = IDLE;
                    rr_nxt    = next_idx(owner);
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        if (!rst_n) begin
            sel_valid = 1'b0;
        end
    end

    always_comb begin
        grant_o   = '0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (sel_valid && (sel_idx == REQ_IDX_W'(i))) begin
                grant_o[i] = 1'b1;
                mem_we     = we_i[i];
                mem_addr   = addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
                mem_wdata  = wdata_i[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign mem_req = sel_valid;
    assign busy    = (state == LOCKED);
    assign rdata_o = mem_rdata;

    // Routing uses resp_owner, not owner, so a reply always returns to the
    // engine that issued the read even across a handover.
    always_comb begin
        valid_o = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            valid_o[i] = rst_n && mem_valid && resp_pend && (resp_owner == REQ_IDX_W'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            owner      <= '0;
            rr_ptr     <= '0;
            resp_owner <= '0;
            resp_pend  <= 1'b0;
        end else begin
            state  <= state_nxt;
            owner  <= owner_nxt;
            rr_ptr <= rr_nxt;
            if (mem_req && !mem_we) begin
                resp_owner <= sel_idx;
                resp_pend  <= 1'b1;
            end else begin
                resp_pend  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench: tb_mem_port_arbiter
// Scoreboard bench for mem_port_arbiter. Stimulus pushes expected grant and
// read-response records (with the cycle they must appear in); a monitor on
// the falling edge pops and compares whenever the DUT drives a grant or a
// valid. A small DRAM model answers reads one cycle later.
module tb_mem_port_arbiter;

    localparam int NR = 4;
    localparam int AW = 24;
    localparam int DW = 8;
`ifdef MEM_ARB_WATCHDOG_EN
    localparam int MH = 8;
`else
    localparam int MH = 1024;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NR-1:0]     req;
    logic [NR-1:0]     we;
    logic [AW-1:0]     addr  [NR];
    logic [DW-1:0]     wdata [NR];
    logic [NR*AW-1:0]  addr_flat;
    logic [NR*DW-1:0]  wdata_flat;
    logic [NR-1:0]     grant_o;
    logic [DW-1:0]     rdata_o;
    logic [NR-1:0]     valid_o;
    logic              mem_req;
    logic              mem_we;
    logic [AW-1:0]     mem_addr;
    logic [DW-1:0]     mem_wdata;
    logic [DW-1:0]     mem_rdata;
    logic              mem_valid;
    logic              busy;
    logic              err;

    logic              dram_valid = 1'b0;
    logic [DW-1:0]     dram_rdata = '0;
    logic              spur = 1'b0;

    int cyc = 0;
    int c = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        int            cyc;
        logic [NR-1:0] grant;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic          busy;
    } g_t;

    typedef struct {
        int            cyc;
        logic [NR-1:0] valid;
        logic [DW-1:0] data;
    } r_t;

    g_t gq[$];
    r_t rq[$];
    g_t ge;
    r_t re;

    int            lo   [NR];
    int            hi   [NR];
    logic [AW-1:0] base [NR];
    int            rlo = 1;
    int            rhi = 0;

    mem_port_arbiter #(
        .NUM_REQ    (NR),
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .MAX_HOLD   (MH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_i     (req),
        .addr_i    (addr_flat),
        .we_i      (we),
        .wdata_i   (wdata_flat),
        .grant_o   (grant_o),
        .rdata_o   (rdata_o),
        .valid_o   (valid_o),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_valid (mem_valid),
        .busy      (busy),
        .err       (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        addr_flat  = '0;
        wdata_flat = '0;
        for (int i = 0; i < NR; i++) begin
            addr_flat[i*AW +: AW]  = addr[i];
            wdata_flat[i*DW +: DW] = wdata[i];
        end
    end

    function automatic logic [DW-1:0] rd_fn(input logic [AW-1:0] a);
        return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h3C;
    endfunction

    // DRAM model: synchronous read, one cycle of latency.
    always @(posedge clk) begin
        dram_valid <= mem_req && !mem_we;
        dram_rdata <= rd_fn(mem_addr);
    end

    assign mem_valid = dram_valid | spur;
    assign mem_rdata = dram_rdata;

    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_req || grant_o != '0) begin
                checks++;
                if (gq.size() == 0) begin
                    errors++;
                    $display("FAIL grant_unexpected cyc=%0d got grant=%b addr=%h we=%b, required none",
                             cyc, grant_o, mem_addr, mem_we);
                end else begin
                    ge = gq.pop_front();
                    if (cyc != ge.cyc || grant_o != ge.grant || !mem_req || mem_we != ge.we ||
                        mem_addr != ge.addr || mem_wdata != ge.wdata || busy != ge.busy) begin
                        errors++;
                        $display("FAIL grant got cyc=%0d grant=%b req=%b we=%b addr=%h wdata=%h busy=%b, required cyc=%0d grant=%b req=1 we=%b addr=%h wdata=%h busy=%b",
                                 cyc, grant_o, mem_req, mem_we, mem_addr, mem_wdata, busy,
                                 ge.cyc, ge.grant, ge.we, ge.addr, ge.wdata, ge.busy);
                    end
                end
            end
            if (valid_o != '0) begin
                checks++;
                if (rq.size() == 0) begin
                    errors++;
                    $display("FAIL valid_unexpected cyc=%0d got valid=%b, required none", cyc, valid_o);
                end else begin
                    re = rq.pop_front();
                    if (cyc != re.cyc || valid_o != re.valid || rdata_o != re.data) begin
                        errors++;
                        $display("FAIL response got cyc=%0d valid=%b data=%h, required cyc=%0d valid=%b data=%h",
                                 cyc, valid_o, rdata_o, re.cyc, re.valid, re.data);
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h required %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_g(input int cc, input int e, input logic w, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic b);
        g_t g;
        g.cyc   = cc;
        g.grant = NR'(1) << e;
        g.we    = w;
        g.addr  = a;
        g.wdata = d;
        g.busy  = b;
        gq.push_back(g);
    endtask

    task automatic exp_r(input int cc, input int e, input logic [AW-1:0] a);
        r_t r;
        r.cyc   = cc;
        r.valid = NR'(1) << e;
        r.data  = rd_fn(a);
        rq.push_back(r);
    endtask

    task automatic exp_rd(input int cc, input int e, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic b);
        exp_g(cc, e, 1'b0, a, d, b);
        exp_r(cc + 1, e, a);
    endtask

    task automatic clear_win();
        for (int i = 0; i < NR; i++) begin
            lo[i] = 1;
            hi[i] = 0;
        end
        rlo = 1;
        rhi = 0;
    endtask

    task automatic begin_test();
        tick();
        c = cyc;
        clear_win();
    endtask

    // Drives n cycles: engine i requests during offsets lo[i]..hi[i] with
    // address base[i]+offset; rst_n is low during offsets rlo..rhi.
    task automatic run_win(input int n);
        for (int k = 0; k < n; k++) begin
            for (int i = 0; i < NR; i++) begin
                req[i]  = (k >= lo[i] && k <= hi[i]);
                addr[i] = base[i] + AW'(k);
            end
            rst_n = !(k >= rlo && k <= rhi);
            tick();
        end
        req   = '0;
        rst_n = 1'b1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = '0;
        we    = '0;
        spur  = 1'b0;
        tick();
        tick();
        @(negedge clk);
        chk("rst_grant",  32'(grant_o),   32'h0);
        chk("rst_valid",  32'(valid_o),   32'h0);
        chk("rst_memreq", 32'(mem_req),   32'h0);
        chk("rst_memwe",  32'(mem_we),    32'h0);
        chk("rst_addr",   32'(mem_addr),  32'h0);
        chk("rst_wdata",  32'(mem_wdata), 32'h0);
        chk("rst_busy",   32'(busy),      32'h0);
        chk("rst_err",    32'(err),       32'h0);
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout at cyc=%0d", cyc);
        $fatal(1, "simulation time limit");
    end

    initial begin
        rst_n = 1'b0;
        req   = '0;
        we    = '0;
        for (int i = 0; i < NR; i++) begin
            addr[i]  = '0;
            wdata[i] = 8'(16 + i);
            base[i]  = '0;
        end
        clear_win();
        do_reset();

        // 1: single engine burst of three reads
        begin_test();
        base[0] = 24'h000100; lo[0] = 0; hi[0] = 2;
        for (int k = 0; k < 3; k++) exp_rd(c + k, 0, 24'h000100 + AW'(k), wdata[0], k != 0);
        run_win(5);

        // 2: all four request; each holds two beats; order 0,1,2,3 with dead cycles
        do_reset();
        begin_test();
        for (int i = 0; i < NR; i++) begin
            base[i] = AW'((i + 1) << 12);
            lo[i]   = 0;
            hi[i]   = 3 * i + 1;
            exp_rd(c + 3 * i,     i, base[i] + AW'(3 * i),     wdata[i], 1'b0);
            exp_rd(c + 3 * i + 1, i, base[i] + AW'(3 * i + 1), wdata[i], 1'b1);
        end
        run_win(13);

        // 3: engine 2 reads 0x10 and drops; engine 0 wins next; reply goes to engine 2
        begin_test();
        base[2] = 24'h000010; lo[2] = 0; hi[2] = 0;
        base[0] = 24'h000030; lo[0] = 1; hi[0] = 2;
        exp_rd(c,     2, 24'h000010, wdata[2], 1'b0);
        exp_rd(c + 2, 0, 24'h000032, wdata[0], 1'b0);
        run_win(5);

        // 4: engine 1 single write, no response
        begin_test();
        we[1] = 1'b1; wdata[1] = 8'hA5;
        base[1] = 24'h000020; lo[1] = 0; hi[1] = 0;
        exp_g(c, 1, 1'b1, 24'h000020, 8'hA5, 1'b0);
        run_win(3);
        we[1] = 1'b0; wdata[1] = 8'h11;

        // 5: spurious mem_valid with nothing outstanding
        tick();
        spur = 1'b1;
        @(negedge clk);
        chk("spurious_valid", 32'(valid_o), 32'h0);
        chk("rdata_bcast",    32'(rdata_o), 32'(dram_rdata));
        tick();
        spur = 1'b0;
        tick();

        // Reset mid-burst: lock and rr pointer are cleared, engine 0 wins after reset
        begin_test();
        base[2] = 24'h600000; lo[2] = 0; hi[2] = 8;
        base[0] = 24'h700000; lo[0] = 4; hi[0] = 4;
        rlo = 2; rhi = 3;
        exp_rd(c,     2, 24'h600000, wdata[2], 1'b0);
        exp_g(c + 1,  2, 1'b0, 24'h600001, wdata[2], 1'b1);
        exp_rd(c + 4, 0, 24'h700004, wdata[0], 1'b0);
        exp_rd(c + 6, 2, 24'h600006, wdata[2], 1'b0);
        exp_rd(c + 7, 2, 24'h600007, wdata[2], 1'b1);
        exp_rd(c + 8, 2, 24'h600008, wdata[2], 1'b1);
        run_win(11);

        // 6: engine 3 holds writes for 20 cycles while engine 0 waits
        do_reset();
        begin_test();
        we[3] = 1'b1;
        base[3] = 24'h400000; lo[3] = 0; hi[3] = 19;
        base[0] = 24'h500000; lo[0] = 1;
`ifdef MEM_ARB_WATCHDOG_EN
        hi[0] = 9;
        for (int k = 0; k < 8; k++) exp_g(c + k, 3, 1'b1, 24'h400000 + AW'(k), wdata[3], k != 0);
        exp_rd(c + 9, 0, 24'h500009, wdata[0], 1'b0);
        for (int k = 11; k < 19; k++) exp_g(c + k, 3, 1'b1, 24'h400000 + AW'(k), wdata[3], k != 11);
        run_win(22);
        chk("wd_err_sticky", 32'(err), 32'h1);
`else
        hi[0] = 21;
        for (int k = 0; k < 20; k++) exp_g(c + k, 3, 1'b1, 24'h400000 + AW'(k), wdata[3], k != 0);
        exp_rd(c + 21, 0, 24'h500015, wdata[0], 1'b0);
        run_win(24);
        chk("err_tied_low", 32'(err), 32'h0);
`endif
        we[3] = 1'b0;

        repeat (3) tick();
        chk("grant_leftover", 32'(gq.size()), 32'h0);
        chk("resp_leftover",  32'(rq.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
